mips_io_bridge: RTL and testbench

Byte-wide I/O bridge between an external host and the MIPS core's `Data_in`/`Data_out`/`Interrupt` pins. It buffers host bytes in an inbound FIFO, presents the FIFO head on `Data_in`, and raises a one-cycle `Interrupt` when input becomes available. It captures core output bytes into an outbound FIFO drained by the host with a valid/ready handshake. It sits directly outside the core top, on the same clock as the core's internal `Clk`.

---
 rtl/mips_io_pkg.sv | 20 ++
 rtl/io_fifo.sv | 54 +++++
 rtl/mips_io_bridge.sv | 115 +++++++++++
 tb/tb_mips_io_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_io_pkg.sv
// rtl/mips_io_pkg.sv - shared types and constants for the MIPS I/O bridge
package mips_io_pkg;

  typedef enum logic [1:0] {
    INT_IDLE  = 2'd0,
    INT_PULSE = 2'd1,
    INT_WAIT  = 2'd2
  } int_state_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 8;

  // Pointers carry one extra wrap bit above the address bits
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - wrap-bit pointer FIFO with combinational head and drop flags
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               empty,
  output logic               full,
  output logic [$clog2(DEPTH):0] count,
  output logic               push_drop,
  output logic               pop_drop
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Flags come from the pre-edge pointers, so a pop cannot make room for a same-cycle push
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_wr_en   = push && !full;
  assign w_rd_en   = pop && !empty;
  assign push_drop = push && full;
  assign pop_drop  = pop && empty;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write at the current write address
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mips_io_bridge.sv
// rtl/mips_io_bridge.sv - host byte FIFOs, interrupt FSM and sticky error flags for the core
module mips_io_bridge
  import mips_io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Host_in_valid,
  input  logic [WIDTH-1:0]       Host_in_data,
  output logic                   Host_in_ready,
  output logic                   Host_out_valid,
  output logic [WIDTH-1:0]       Host_out_data,
  input  logic                   Host_out_ready,
  output logic [WIDTH-1:0]       Data_in,
  input  logic                   In_pop,
  input  logic [WIDTH-1:0]       Data_out,
  input  logic                   Out_push,
  input  logic                   Int_en,
  output logic                   Interrupt,
  output logic [ptr_width(DEPTH)-1:0] In_count,
  output logic                   Out_overflow,
  output logic                   In_underflow
);

  logic                        w_in_empty;
  logic                        w_in_full;
  logic                        w_in_push_drop;
  logic                        w_in_pop_drop;
  logic                        w_out_empty;
  logic                        w_out_full;
  logic [ptr_width(DEPTH)-1:0] w_out_count;
  logic                        w_out_push_drop;
  logic                        w_out_pop_drop;
  logic                        w_unused_ok;
  int_state_t                  r_state;
  int_state_t                  w_state_nxt;
  logic                        r_interrupt;
  logic                        r_out_overflow;
  logic                        r_in_underflow;

  // Host writes into the inbound FIFO; the core reads its head
  io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (Host_in_valid),
    .pop       (In_pop),
    .din       (Host_in_data),
    .dout      (Data_in),
    .empty     (w_in_empty),
    .full      (w_in_full),
    .count     (In_count),
    .push_drop (w_in_push_drop),
    .pop_drop  (w_in_pop_drop)
  );

  // Core writes into the outbound FIFO; the host drains it
  io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (Out_push),
    .pop       (Host_out_ready),
    .din       (Data_out),
    .dout      (Host_out_data),
    .empty     (w_out_empty),
    .full      (w_out_full),
    .count     (w_out_count),
    .push_drop (w_out_push_drop),
    .pop_drop  (w_out_pop_drop)
  );

  assign Host_in_ready  = !w_in_full;
  assign Host_out_valid = !w_out_empty;
  assign Interrupt      = r_interrupt;
  assign Out_overflow   = r_out_overflow;
  assign In_underflow   = r_in_underflow;

  // Status the bridge does not act on; a blocked host write or an idle host read is normal flow
  assign w_unused_ok = &{1'b0, w_in_push_drop, w_out_full, w_out_count, w_out_pop_drop};

  // Interrupt state register plus registered pulse output
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= INT_IDLE;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= (w_state_nxt == INT_PULSE);
    end
  end

  // One pulse per arrival episode; WAIT holds off until input drains or the enable drops
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INT_IDLE:  if (Int_en && !w_in_empty) w_state_nxt = INT_PULSE;
      INT_PULSE: w_state_nxt = INT_WAIT;
      INT_WAIT:  if (!Int_en || w_in_empty) w_state_nxt = INT_IDLE;
      default:   w_state_nxt = INT_IDLE;
    endcase
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_overflow <= 1'b0;
      r_in_underflow <= 1'b0;
    end else begin
      if (w_out_push_drop) r_out_overflow <= 1'b1;
      if (w_in_pop_drop)   r_in_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_io_bridge.sv
// tb/tb_mips_io_bridge.sv - scoreboard bench for mips_io_bridge
module tb_mips_io_bridge;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Host_in_valid;
  logic [WIDTH-1:0] Host_in_data;
  logic             Host_in_ready;
  logic             Host_out_valid;
  logic [WIDTH-1:0] Host_out_data;
  logic             Host_out_ready;
  logic [WIDTH-1:0] Data_in;
  logic             In_pop;
  logic [WIDTH-1:0] Data_out;
  logic             Out_push;
  logic             Int_en;
  logic             Interrupt;
  logic [2:0]       In_count;
  logic             Out_overflow;
  logic             In_underflow;

  int n_cmp = 0;
  int n_err = 0;
  int int_cnt = 0;
  logic [WIDTH-1:0] q_in[$];
  logic [WIDTH-1:0] q_out[$];

  mips_io_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .Host_in_valid  (Host_in_valid),
    .Host_in_data   (Host_in_data),
    .Host_in_ready  (Host_in_ready),
    .Host_out_valid (Host_out_valid),
    .Host_out_data  (Host_out_data),
    .Host_out_ready (Host_out_ready),
    .Data_in        (Data_in),
    .In_pop         (In_pop),
    .Data_out       (Data_out),
    .Out_push       (Out_push),
    .Int_en         (Int_en),
    .Interrupt      (Interrupt),
    .In_count       (In_count),
    .Out_overflow   (Out_overflow),
    .In_underflow   (In_underflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on the falling edge, any handshake due at the next rising edge is scored
  initial forever begin
    @(negedge Clk);
    if (Interrupt === 1'b1) int_cnt++;
    if (Reset_n && In_pop && In_count != 0) begin
      n_cmp++;
      if (q_in.size() == 0) begin
        n_err++;
        $display("FAIL sb_in: unexpected pop of %0h, expected none", Data_in);
      end else begin
        logic [WIDTH-1:0] e;
        e = q_in.pop_front();
        if (Data_in !== e) begin
          n_err++;
          $display("FAIL sb_in: got %0h, expected %0h", Data_in, e);
        end
      end
    end
    if (Reset_n && Host_out_valid && Host_out_ready) begin
      n_cmp++;
      if (q_out.size() == 0) begin
        n_err++;
        $display("FAIL sb_out: unexpected read of %0h, expected none", Host_out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = q_out.pop_front();
        if (Host_out_data !== e) begin
          n_err++;
          $display("FAIL sb_out: got %0h, expected %0h", Host_out_data, e);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, Host_in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, Host_out_valid}, 32'd0);
    check({tag, "_out_data"},  {24'd0, Host_out_data},  32'd0);
    check({tag, "_data_in"},   {24'd0, Data_in},        32'd0);
    check({tag, "_interrupt"}, {31'd0, Interrupt},      32'd0);
    check({tag, "_in_count"},  {29'd0, In_count},       32'd0);
    check({tag, "_overflow"},  {31'd0, Out_overflow},   32'd0);
    check({tag, "_underflow"}, {31'd0, In_underflow},   32'd0);
  endtask

  task automatic host_write(input logic [WIDTH-1:0] d);
    Host_in_valid = 1'b1;
    Host_in_data  = d;
    tick();
    Host_in_valid = 1'b0;
  endtask

  task automatic core_pops(input int n);
    In_pop = 1'b1;
    repeat (n) tick();
    In_pop = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    Host_in_valid = 1'b0; Host_in_data = '0; Host_out_ready = 1'b0;
    In_pop = 1'b0; Data_out = '0; Out_push = 1'b0; Int_en = 1'b0;
    tick(); tick();
    check_reset_outputs("rst");
    Reset_n = 1'b1;
    tick();

    // Single write with interrupts enabled
    Int_en = 1'b1;
    host_write(8'hA5);
    check("a5_data_in", {24'd0, Data_in}, 32'hA5);
    check("a5_count", {29'd0, In_count}, 32'd1);
    check("a5_int_early", {31'd0, Interrupt}, 32'd0);
    tick();
    check("a5_int_pulse", {31'd0, Interrupt}, 32'd1);
    tick();
    check("a5_int_end", {31'd0, Interrupt}, 32'd0);
    q_in.push_back(8'hA5);
    core_pops(1);
    tick();
    check("a5_int_cnt", int_cnt, 32'd1);

    // Fill inbound past full, then drain
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("fill_ready_%0d", i), {31'd0, Host_in_ready}, (i <= 4) ? 32'd1 : 32'd0);
      host_write(i[7:0]);
    end
    check("fill_count", {29'd0, In_count}, 32'd4);
    check("fill_ready_after", {31'd0, Host_in_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) q_in.push_back(i[7:0]);
    core_pops(4);
    check("drain_data_in", {24'd0, Data_in}, 32'd0);
    check("drain_count", {29'd0, In_count}, 32'd0);
    tick();
    check("fill_int_cnt", int_cnt, 32'd2);

    // Outbound overflow
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_before", {31'd0, Out_overflow}, 32'd0);
      Out_push = 1'b1;
      Data_out = 8'h10 + i[7:0];
      tick();
      if (i == 0) check("out_latency", {31'd0, Host_out_valid}, 32'd1);
    end
    Out_push = 1'b0;
    check("ovf_set", {31'd0, Out_overflow}, 32'd1);
    check("out_head", {24'd0, Host_out_data}, 32'h10);
    for (int i = 0; i < 4; i++) q_out.push_back(8'h10 + i[7:0]);
    Host_out_ready = 1'b1;
    repeat (4) tick();
    Host_out_ready = 1'b0;
    check("out_empty_valid", {31'd0, Host_out_valid}, 32'd0);
    check("out_empty_data", {24'd0, Host_out_data}, 32'd0);
    check("ovf_sticky", {31'd0, Out_overflow}, 32'd1);

    // Underflow, then simultaneous push/pop with two entries held
    check("udf_before", {31'd0, In_underflow}, 32'd0);
    core_pops(1);
    check("udf_set", {31'd0, In_underflow}, 32'd1);
    check("udf_count", {29'd0, In_count}, 32'd0);
    host_write(8'h21);
    host_write(8'h22);
    q_in.push_back(8'h21);
    Host_in_valid = 1'b1; Host_in_data = 8'h23; In_pop = 1'b1;
    tick();
    Host_in_valid = 1'b0; In_pop = 1'b0;
    check("pp_count", {29'd0, In_count}, 32'd2);
    check("pp_head", {24'd0, Data_in}, 32'h22);
    q_in.push_back(8'h22); q_in.push_back(8'h23);
    core_pops(2);
    tick();
    check("pp_int_cnt", int_cnt, 32'd3);

    // Enable edge with pending data, then no re-pulse until drain and refill
    Int_en = 1'b0;
    host_write(8'h31);
    tick(); tick();
    check("en_off_int_cnt", int_cnt, 32'd3);
    Int_en = 1'b1;
    tick(); tick(); tick();
    check("en_rise_int_cnt", int_cnt, 32'd4);
    host_write(8'h32);
    host_write(8'h33);
    tick(); tick();
    check("hold_int_cnt", int_cnt, 32'd4);
    q_in.push_back(8'h31); q_in.push_back(8'h32); q_in.push_back(8'h33);
    core_pops(3);
    tick(); tick();
    host_write(8'h34);
    tick(); tick();
    check("refill_int_cnt", int_cnt, 32'd5);

    // Mid-operation reset with three entries in each FIFO
    host_write(8'h35);
    host_write(8'h36);
    for (int i = 0; i < 3; i++) begin
      Out_push = 1'b1;
      Data_out = 8'h41 + i[7:0];
      tick();
    end
    Out_push = 1'b0;
    check("pre_rst_in_count", {29'd0, In_count}, 32'd3);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Continuous traffic wrapping both pointers
    for (int i = 0; i < 8; i++) begin
      q_in.push_back(8'h50 + i[7:0]);
      q_out.push_back(8'h60 + i[7:0]);
    end
    Host_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Host_in_valid = 1'b1; Host_in_data = 8'h50 + i[7:0];
      In_pop = (i > 0);
      Out_push = 1'b1; Data_out = 8'h60 + i[7:0];
      tick();
    end
    Host_in_valid = 1'b0; Out_push = 1'b0; In_pop = 1'b1;
    tick();
    In_pop = 1'b0; Host_out_ready = 1'b0;
    check("wrap_in_count", {29'd0, In_count}, 32'd0);
    check("wrap_out_valid", {31'd0, Host_out_valid}, 32'd0);
    check("wrap_udf", {31'd0, In_underflow}, 32'd0);
    check("wrap_ovf", {31'd0, Out_overflow}, 32'd0);
    check("wrap_q_in_left", q_in.size(), 32'd0);
    check("wrap_q_out_left", q_out.size(), 32'd0);
    tick();
    check("wrap_int_cnt", int_cnt, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
